// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ALU operation classes, ALU control codes and the controller state encoding.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned STATE_W  = 4;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

  // ALU operation classes handed from the FSM to the ALU decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

  // ALU control codes
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IWB     = 4'd12,
    S_JEX     = 4'd13
  } state_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic is_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_J: is_supported = 1'b1;
      default:               is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class and R-type funct field to an ALU control code.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown functs fall back to add rather than flagging an error
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_OR:  alucontrol = ALU_OR;
      default: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath: one state per microstep.
// Outputs decode from the state register; while reset is low they are all held
// at zero so no write can happen in the reset cycle.
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       extop,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t     state;
  logic [1:0] aluop;
  logic [2:0] alu_dec;
  logic       pcwrite;
  logic       branch;
  logic       branchne;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_dec)
  );

  // State register with synchronous active-low reset and next-state selection
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_BNE:       state <= S_BNEEX;
            OP_ADDI:      state <= S_ADDIEX;
            OP_ORI:       state <= S_ORIEX;
            OP_J:         state <= S_JEX;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (op == OP_LW)      state <= S_MEMRD;
          else if (op == OP_SW) state <= S_MEMWR;
          else                  state <= S_FETCH;
        end
        S_MEMRD:   state <= S_MEMWB;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_ADDIEX:  state <= S_IWB;
        S_ORIEX:   state <= S_IWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls, all forced low while reset is asserted
  always_comb begin
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    extop      = 1'b0;
    illegal    = 1'b0;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    alucontrol = 3'b000;
    pcen       = 1'b0;
    if (reset) begin
      extop = 1'b1;
      case (state)
        S_FETCH: begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          alusrcb = 2'b01;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          illegal = ~is_supported(op);
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_BNEEX: begin
          alusrca  = 1'b1;
          aluop    = ALUOP_SUB;
          pcsrc    = 2'b01;
          branchne = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ORIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = ALUOP_OR;
          extop   = 1'b0;
        end
        S_IWB: regwrite = 1'b1;
        S_JEX: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
      alucontrol = alu_dec;
      pcen       = pcwrite | (branch & zero) | (branchne & ~zero);
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a per-cycle vector table of inputs and
// expected outputs, followed by hand-written illegal-opcode and reset sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       extop;
  logic [2:0] alucontrol;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          z;
    logic [16:0]   exp;
    logic [8*8-1:0] tag;
  } vec_t;

  vec_t vecs[$];

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .extop      (extop),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Output word order: pcen mw ir rw iord m2r rd asa asb[2] pcs[2] ext alu[3] ill
  function automatic logic [16:0] pk(input logic pc, input logic mw, input logic ir,
                                     input logic rw, input logic io, input logic m2r,
                                     input logic rd, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic ext,
                                     input logic [2:0] alu, input logic ill);
    pk = {pc, mw, ir, rw, io, m2r, rd, asa, asb, pcs, ext, alu, ill};
  endfunction

  function automatic logic [16:0] actual();
    actual = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
              alusrcb, pcsrc, extop, alucontrol, illegal};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [16:0] e, input logic [8*8-1:0] t);
    vec_t v;
    v.rst = r; v.op = o; v.fn = f; v.z = z; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic check(input logic [16:0] act, input logic [16:0] exp, input logic [8*8-1:0] t,
                       input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s[%0d]: got %b, want %b", t, idx, act, exp);
    end
  endtask

  // Hand-computed expected output words per state
  logic [16:0] e_zero, e_fetch, e_dec, e_decill, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [16:0] e_rwb, e_addiex, e_oriex, e_iwb, e_jex;
  logic [16:0] e_rsub, e_rand, e_rslt, e_radd, e_runk;
  logic [16:0] e_br1, e_br0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    logic [3:0] ill_seq, ir_seq;
    int waits;
    bit found;

    e_zero   = 17'd0;
    e_fetch  = pk(1,0,1,0,0,0,0,0,2'b01,2'b00,1,3'b010,0);
    e_dec    = pk(0,0,0,0,0,0,0,0,2'b11,2'b00,1,3'b010,0);
    e_decill = pk(0,0,0,0,0,0,0,0,2'b11,2'b00,1,3'b010,1);
    e_memadr = pk(0,0,0,0,0,0,0,1,2'b10,2'b00,1,3'b010,0);
    e_memrd  = pk(0,0,0,0,1,0,0,0,2'b00,2'b00,1,3'b010,0);
    e_memwb  = pk(0,0,0,1,0,1,0,0,2'b00,2'b00,1,3'b010,0);
    e_memwr  = pk(0,1,0,0,1,0,0,0,2'b00,2'b00,1,3'b010,0);
    e_rsub   = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,1,3'b110,0);
    e_rand   = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,1,3'b000,0);
    e_rslt   = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,1,3'b111,0);
    e_radd   = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,1,3'b010,0);
    e_runk   = pk(0,0,0,0,0,0,0,1,2'b00,2'b00,1,3'b010,0);
    e_rwb    = pk(0,0,0,1,0,0,1,0,2'b00,2'b00,1,3'b010,0);
    e_br1    = pk(1,0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0);
    e_br0    = pk(0,0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0);
    e_addiex = pk(0,0,0,0,0,0,0,1,2'b10,2'b00,1,3'b010,0);
    e_oriex  = pk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,3'b001,0);
    e_iwb    = pk(0,0,0,1,0,0,0,0,2'b00,2'b00,1,3'b010,0);
    e_jex    = pk(1,0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);

    // reset held three cycles
    for (int i = 0; i < 3; i++) add(0, LW, 6'h00, 0, e_zero, "reset");
    // lw
    add(1, LW, 6'h00, 0, e_fetch, "lw_f"); add(1, LW, 6'h00, 0, e_dec, "lw_d");
    add(1, LW, 6'h00, 0, e_memadr, "lw_ma"); add(1, LW, 6'h00, 0, e_memrd, "lw_rd");
    add(1, LW, 6'h00, 0, e_memwb, "lw_wb");
    // R-type sub, and, slt, add, unknown funct
    add(1, RT, 6'b100010, 0, e_fetch, "sub_f"); add(1, RT, 6'b100010, 0, e_dec, "sub_d");
    add(1, RT, 6'b100010, 0, e_rsub, "sub_ex"); add(1, RT, 6'b100010, 0, e_rwb, "sub_wb");
    add(1, RT, 6'b100100, 0, e_fetch, "and_f"); add(1, RT, 6'b100100, 0, e_dec, "and_d");
    add(1, RT, 6'b100100, 0, e_rand, "and_ex"); add(1, RT, 6'b100100, 0, e_rwb, "and_wb");
    add(1, RT, 6'b101010, 0, e_fetch, "slt_f"); add(1, RT, 6'b101010, 0, e_dec, "slt_d");
    add(1, RT, 6'b101010, 0, e_rslt, "slt_ex"); add(1, RT, 6'b101010, 0, e_rwb, "slt_wb");
    add(1, RT, 6'b100000, 0, e_fetch, "add_f"); add(1, RT, 6'b100000, 0, e_dec, "add_d");
    add(1, RT, 6'b100000, 0, e_radd, "add_ex"); add(1, RT, 6'b100000, 0, e_rwb, "add_wb");
    add(1, RT, 6'b111111, 0, e_fetch, "unk_f"); add(1, RT, 6'b111111, 0, e_dec, "unk_d");
    add(1, RT, 6'b111111, 0, e_runk, "unk_ex"); add(1, RT, 6'b111111, 0, e_rwb, "unk_wb");
    // sw
    add(1, SW, 6'h00, 0, e_fetch, "sw_f"); add(1, SW, 6'h00, 0, e_dec, "sw_d");
    add(1, SW, 6'h00, 0, e_memadr, "sw_ma"); add(1, SW, 6'h00, 0, e_memwr, "sw_wr");
    // beq / bne with both zero values; FETCH pcen must ignore zero
    add(1, BEQ, 6'h00, 1, e_fetch, "beq1_f"); add(1, BEQ, 6'h00, 1, e_dec, "beq1_d");
    add(1, BEQ, 6'h00, 1, e_br1, "beq1_ex");
    add(1, BEQ, 6'h00, 0, e_fetch, "beq0_f"); add(1, BEQ, 6'h00, 0, e_dec, "beq0_d");
    add(1, BEQ, 6'h00, 0, e_br0, "beq0_ex");
    add(1, BNE, 6'h00, 1, e_fetch, "bne1_f"); add(1, BNE, 6'h00, 1, e_dec, "bne1_d");
    add(1, BNE, 6'h00, 1, e_br0, "bne1_ex");
    add(1, BNE, 6'h00, 0, e_fetch, "bne0_f"); add(1, BNE, 6'h00, 0, e_dec, "bne0_d");
    add(1, BNE, 6'h00, 0, e_br1, "bne0_ex");
    // j
    add(1, J, 6'h00, 0, e_fetch, "j_f"); add(1, J, 6'h00, 0, e_dec, "j_d");
    add(1, J, 6'h00, 0, e_jex, "j_ex");
    // ori, addi
    add(1, ORI, 6'h00, 0, e_fetch, "ori_f"); add(1, ORI, 6'h00, 0, e_dec, "ori_d");
    add(1, ORI, 6'h00, 0, e_oriex, "ori_ex"); add(1, ORI, 6'h00, 0, e_iwb, "ori_wb");
    add(1, ADDI, 6'h00, 0, e_fetch, "addi_f"); add(1, ADDI, 6'h00, 0, e_dec, "addi_d");
    add(1, ADDI, 6'h00, 0, e_addiex, "addi_ex"); add(1, ADDI, 6'h00, 0, e_iwb, "addi_wb");
    // illegal opcode
    add(1, BAD, 6'h00, 0, e_fetch, "ill_f"); add(1, BAD, 6'h00, 0, e_decill, "ill_d");
    // lw interrupted by reset in MEMRD
    add(1, LW, 6'h00, 0, e_fetch, "lwr_f"); add(1, LW, 6'h00, 0, e_dec, "lwr_d");
    add(1, LW, 6'h00, 0, e_memadr, "lwr_ma"); add(0, LW, 6'h00, 0, e_zero, "lwr_rst");
    add(1, LW, 6'h00, 0, e_fetch, "lwr_f2"); add(1, LW, 6'h00, 0, e_dec, "lwr_d2");

    reset = 1'b0; op = LW; funct = 6'h00; zero = 1'b0;

    // Each record holds for one cycle; outputs sampled at the falling edge
    foreach (vecs[i]) begin
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
      @(negedge clk);
      check(actual(), vecs[i].exp, vecs[i].tag, i);
      @(posedge clk); #1;
    end

    // Illegal opcode: one-cycle pulse alternating with FETCH
    reset = 1'b0; op = BAD; zero = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ill_seq = 4'd0; ir_seq = 4'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ill_seq = {ill_seq[2:0], illegal};
      ir_seq  = {ir_seq[2:0], irwrite};
      @(posedge clk); #1;
    end
    check({13'd0, ill_seq}, {13'd0, 4'b0101}, "ill_seq", 0);
    check({13'd0, ir_seq}, {13'd0, 4'b1010}, "ir_seq", 0);

    // sw abandoned by reset in MEMWR: no write strobe in the reset cycle
    reset = 1'b0; op = SW;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    @(negedge clk);
    check(actual(), e_memwr, "swr_wr", 0);
    reset = 1'b0;
    #1;
    check(actual(), e_zero, "swr_rst", 0);
    @(posedge clk); #1;
    reset = 1'b1;
    found = 1'b0; waits = 0;
    while (!found && waits < 8) begin
      @(negedge clk);
      if (irwrite) found = 1'b1;
      else begin waits++; @(posedge clk); #1; end
    end
    check({16'd0, found}, 17'd1, "swr_fnd", 0);
    check(17'(waits), 17'd0, "swr_wait", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
